// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pool block: default geometry,
// line-pair phase encoding and the three-channel pixel triple.
package pool_pkg;

    localparam int POOL_DATA_W = 20;
    localparam int POOL_LINE_W = 24;
    localparam int POOL_LINE_H = 24;

    // PH_A holds the even column of a horizontal pair, PH_B the odd one
    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } pool_phase_e;

    // One sample across all three convolution channels (default width)
    typedef struct packed {
        logic signed [POOL_DATA_W-1:0] ch1;
        logic signed [POOL_DATA_W-1:0] ch2;
        logic signed [POOL_DATA_W-1:0] ch3;
    } pix_t;

endpackage

// File: rtl/pool_line_buf.sv
// Half-line store for the horizontal maxima of an even row.
// One synchronous write port, one asynchronous read port. Contents are
// never reset: every entry is written on the even row before the odd row
// reads it back.
module pool_line_buf #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 12,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   i_wr_en,
    input  logic [AW-1:0]          i_wr_addr,
    input  logic [2:0][DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]          i_rd_addr,
    output logic [2:0][DATA_W-1:0] o_rd_data
);

    logic [2:0][DATA_W-1:0] r_mem [DEPTH];

    // Write the horizontal max of the current pair on the even row
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 max pooling over three signed convolution channels, streamed in
// raster order. Even columns are parked in a pair register, odd columns
// produce a horizontal max; even rows park that in a half-line buffer,
// odd rows combine it into the registered output.
// Optional feature: define POOL_RELU_EN to clamp negative inputs to 0
// before any comparison.
module max_pool_2x2
    import pool_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int LINE_W = POOL_LINE_W,  // even, >= 4
    parameter int LINE_H = POOL_LINE_H   // even, >= 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] conv_out_1,
    input  logic signed [DATA_W-1:0] conv_out_2,
    input  logic signed [DATA_W-1:0] conv_out_3,
    input  logic                     valid_out,
    output logic                     ready_pool,
    output logic signed [DATA_W-1:0] pool_out_1,
    output logic signed [DATA_W-1:0] pool_out_2,
    output logic signed [DATA_W-1:0] pool_out_3,
    output logic                     valid_pool,
    input  logic                     ready_next,
    output logic                     frame_done
);

    localparam int COL_W  = $clog2(LINE_W);
    localparam int ROW_W  = (LINE_H > 2) ? $clog2(LINE_H) : 1;
    localparam int HALF_W = LINE_W / 2;
    localparam int AW     = COL_W - 1;

    logic [COL_W-1:0]       r_col;
    logic [ROW_W-1:0]       r_row;
    pool_phase_e            r_phase;
    logic [2:0][DATA_W-1:0] r_pair;
    logic [2:0][DATA_W-1:0] r_out;
    logic                   r_valid;
    logic                   r_last;
    logic                   r_frame_done;

    logic [2:0][DATA_W-1:0] w_in;
    logic [2:0][DATA_W-1:0] w_hmax;
    logic [2:0][DATA_W-1:0] w_vmax;
    logic [2:0][DATA_W-1:0] w_lb_rd;
    logic                   w_odd_row;
    logic                   w_last_col;
    logic                   w_last_row;
    logic                   w_accept;
    logic                   w_out_ack;
    logic                   w_load;
    logic                   w_lb_we;

    function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    assign w_odd_row  = r_row[0];
    assign w_last_col = (r_col == COL_W'(LINE_W - 1));
    assign w_last_row = (r_row == ROW_W'(LINE_H - 1));

    // Only the odd-row result slot can be blocked; everything else always drains
    assign ready_pool = !(w_odd_row && (r_phase == PH_B) && r_valid && !ready_next);
    assign w_accept   = valid_out && ready_pool;
    assign w_out_ack  = r_valid && ready_next;
    assign w_load     = w_accept && (r_phase == PH_B) && w_odd_row;
    assign w_lb_we    = w_accept && (r_phase == PH_B) && !w_odd_row;

    // Gather the incoming triple, optionally rectified
    always_comb begin
        w_in[0] = conv_out_1;
        w_in[1] = conv_out_2;
        w_in[2] = conv_out_3;
`ifdef POOL_RELU_EN
        for (int c = 0; c < 3; c++) begin
            if (w_in[c][DATA_W-1]) w_in[c] = '0;
        end
`endif
    end

    // Horizontal max against the parked even column, then vertical max
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            w_hmax[c] = smax(r_pair[c], w_in[c]);
            w_vmax[c] = smax(w_hmax[c], w_lb_rd[c]);
        end
    end

    pool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (HALF_W),
        .AW     (AW)
    ) u_line_buf (
        .clk       (clk),
        .i_wr_en   (w_lb_we),
        .i_wr_addr (r_col[COL_W-1:1]),
        .i_wr_data (w_hmax),
        .i_rd_addr (r_col[COL_W-1:1]),
        .o_rd_data (w_lb_rd)
    );

    // Raster counters, pair phase and even-column capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_phase <= PH_A;
            r_pair  <= '0;
        end else if (w_accept) begin
            r_phase <= (r_phase == PH_A) ? PH_B : PH_A;
            if (r_phase == PH_A) r_pair <= w_in;
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Output slot: load on odd-row pair completion, hold until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_out_ack && r_last;
            if (w_load) begin
                r_out   <= w_vmax;
                r_valid <= 1'b1;
                r_last  <= w_last_col && w_last_row;
            end else if (w_out_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pool_out_1 = r_out[0];
    assign pool_out_2 = r_out[1];
    assign pool_out_3 = r_out[2];
    assign valid_pool = r_valid;
    assign frame_done = r_frame_done;

endmodule
